// File: rtl/game_pkg.sv
// Shared game constants: cheese spawn slot table, LFSR taps and spawner state encoding.
package game_pkg;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } pos_t;

    typedef enum logic [1:0] {
        SHOW = 2'd0,
        HIDE = 2'd1,
        PICK = 2'd2
    } spawn_state_t;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting left (bits 15,13,12,10)
    localparam logic [15:0] CHEESE_LFSR_TAPS = 16'hB400;

    // Top-left corners of cheese resting spots, each sitting on a platform
    localparam pos_t CHEESE_SLOTS [16] = '{
        '{12'd64,  12'd400}, '{12'd160, 12'd336}, '{12'd256, 12'd272}, '{12'd352, 12'd208},
        '{12'd448, 12'd400}, '{12'd544, 12'd336}, '{12'd640, 12'd272}, '{12'd736, 12'd208},
        '{12'd96,  12'd144}, '{12'd192, 12'd464}, '{12'd288, 12'd144}, '{12'd384, 12'd464},
        '{12'd480, 12'd80},  '{12'd576, 12'd528}, '{12'd672, 12'd80},  '{12'd768, 12'd528}
    };

endpackage

// File: rtl/cheese_spawner_if.sv
// Position bus: a 12-bit x/y top-left coordinate pair.
interface pos_if;
    logic [11:0] x;
    logic [11:0] y;

    modport out    (output x, y);
    modport in     (input  x, y);
    modport master (output x, y);
    modport slave  (input  x, y);
endinterface

// File: rtl/cheese_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running; seed is loaded on rst and must be nonzero.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) value <= seed;
        else     value <= {value[14:0], ^(value & CHEESE_LFSR_TAPS)};
    end

endmodule

// File: rtl/cheese_spawner.sv
// Cheese spawner: hides the cheese after a pickup, then respawns it at an LFSR-chosen slot.
// Optional CHEESE_SPAWN_BLINK_EN blinks the old cheese during the last 32 hidden frames.
module cheese_spawner
    import game_pkg::*;
#(
    parameter int          NUM_SLOTS      = 8,
    parameter int          RESPAWN_FRAMES = 60,
    parameter int          MAX_TRIES      = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic reset,
    input  logic frame_tick,
    input  logic cheese_taken,
    pos_if.out   cheesepos,
    output logic cheese_visible,
    output logic cheese_spawned
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int FRM_W = ($clog2(RESPAWN_FRAMES) > 3) ? $clog2(RESPAWN_FRAMES) : 3;

    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(RESPAWN_FRAMES - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLOTS - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_SLOTS);
`ifdef CHEESE_SPAWN_BLINK_EN
    localparam logic [FRM_W-1:0] BLINK_START =
        FRM_W'((RESPAWN_FRAMES > 32) ? RESPAWN_FRAMES - 32 : 0);
`endif

    spawn_state_t     state;
    logic [IDX_W-1:0] slot_idx;
    logic [FRM_W-1:0] frm_ctr;
    logic [TRY_W-1:0] try_ctr;
    logic [15:0]      lfsr;

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] wrap_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [FRM_W-1:0] frm_nxt;
    logic             accept;
    logic             unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .value (lfsr)
    );

    // Only the low IDX_W bits pick a slot; the rest just keep the sequence long
    assign unused_lfsr = ^lfsr[15:IDX_W];

    assign cand     = lfsr[IDX_W-1:0];
    assign accept   = ({1'b0, cand} < NUM_EXT) && (cand != slot_idx);
    assign wrap_idx = (slot_idx == IDX_LAST) ? '0 : slot_idx + IDX_W'(1);
    assign nxt_idx  = accept ? cand : wrap_idx;
    assign frm_nxt  = frm_ctr + FRM_W'(1);

    always_ff @(posedge clk) begin
        cheese_spawned <= 1'b0;
        if (rst || reset) begin
            state          <= SHOW;
            slot_idx       <= '0;
            cheesepos.x    <= CHEESE_SLOTS[0].x;
            cheesepos.y    <= CHEESE_SLOTS[0].y;
            cheese_visible <= 1'b1;
            frm_ctr        <= '0;
            try_ctr        <= '0;
        end else begin
            case (state)
                SHOW: begin
                    if (cheese_taken) begin
                        state          <= HIDE;
                        cheese_visible <= 1'b0;
                        frm_ctr        <= '0;
                    end
                end
                HIDE: begin
                    if (frame_tick) begin
                        if (frm_ctr == FRM_LAST) begin
                            state          <= PICK;
                            try_ctr        <= '0;
                            cheese_visible <= 1'b0;
                        end else begin
                            frm_ctr <= frm_nxt;
`ifdef CHEESE_SPAWN_BLINK_EN
                            cheese_visible <= (frm_nxt >= BLINK_START) && frm_nxt[2];
`endif
                        end
                    end
                end
                PICK: begin
                    // Last try falls back to the next slot so the pick always terminates
                    if (accept || try_ctr == TRY_LAST) begin
                        state          <= SHOW;
                        slot_idx       <= nxt_idx;
                        cheesepos.x    <= CHEESE_SLOTS[4'(nxt_idx)].x;
                        cheesepos.y    <= CHEESE_SLOTS[4'(nxt_idx)].y;
                        cheese_visible <= 1'b1;
                        cheese_spawned <= 1'b1;
                    end else begin
                        try_ctr <= try_ctr + TRY_W'(1);
                    end
                end
                default: state <= SHOW;
            endcase
        end
    end

endmodule

// File: tb/tb_cheese_spawner.sv
// Scoreboard bench: stimulus pushes the expected respawn slot/latency, a monitor checks each spawn.
module tb_cheese_spawner;
    import game_pkg::*;

    localparam int RESP = 60;
`ifdef CHEESE_SPAWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct {
        int slot;
        int lat;
        int t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic reset1 = 1'b0, tick1 = 1'b0, take1 = 1'b0, vis1, spn1;
    logic reset2 = 1'b0, tick2 = 1'b0, take2 = 1'b0, vis2, spn2;

    pos_if p1 ();
    pos_if p2 ();

    cheese_spawner #(.NUM_SLOTS(8), .RESPAWN_FRAMES(RESP), .MAX_TRIES(4), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst(rst), .reset(reset1), .frame_tick(tick1), .cheese_taken(take1),
        .cheesepos(p1), .cheese_visible(vis1), .cheese_spawned(spn1)
    );

    cheese_spawner #(.NUM_SLOTS(5), .RESPAWN_FRAMES(1), .MAX_TRIES(1), .LFSR_SEED(16'hACE1)) dut2 (
        .clk(clk), .rst(rst), .reset(reset2), .frame_tick(tick2), .cheese_taken(take2),
        .cheesepos(p2), .cheese_visible(vis2), .cheese_spawned(spn2)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] m;
    exp_t        q1[$];
    exp_t        q2[$];
    int          cur1 = 0, cur2 = 0, prev2 = 0;
    logic [15:0] used2 = '0;
    logic        wrap2 = 1'b0;

    // Independent model of x^16+x^14+x^13+x^11+1, same seed and reset as both DUTs
    always @(posedge clk) begin
        m   <= rst ? 16'hACE1 : {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [11:0] x, input logic [11:0] y);
        for (int i = 0; i < 16; i++)
            if (CHEESE_SLOTS[i].x == x && CHEESE_SLOTS[i].y == y) return i;
        return -1;
    endfunction

    // Expected slot given the LFSR value seen on the first PICK cycle
    function automatic int pick(input logic [15:0] l0, input int old, input int num,
                                input int tries, output int lat);
        logic [15:0] l;
        int w, cand;
        l = l0;
        w = $clog2(num);
        for (int t = 0; t < tries; t++) begin
            cand = int'(l) & ((1 << w) - 1);
            if (cand < num && cand != old) begin
                lat = t + 1;
                return cand;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        lat = tries;
        return (old == num - 1) ? 0 : old + 1;
    endfunction

    function automatic logic exp_vis(input int k);
        return BLINK && (k >= RESP - 32) && k[2];
    endfunction

    always @(negedge clk) begin
        if (spn1) begin
            exp_t e;
            check("spawn1_pending", 32'(q1.size() != 0), 32'(1));
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("spawn1_slot", 32'(idx_of(p1.x, p1.y)), 32'(e.slot));
                check("spawn1_latency", 32'(cyc - e.t0), 32'(e.lat));
                check("spawn1_visible", 32'(vis1), 32'(1));
            end
        end
    end

    always @(negedge clk) begin
        if (spn2) begin
            exp_t e;
            int a;
            a = idx_of(p2.x, p2.y);
            check("spawn2_range", 32'(a >= 0 && a < 5), 32'(1));
            check("spawn2_differs", 32'(a != prev2), 32'(1));
            if (prev2 == 4 && a == 0) wrap2 = 1'b1;
            if (a >= 0 && a < 16) used2[a] = 1'b1;
            prev2 = a;
            check("spawn2_pending", 32'(q2.size() != 0), 32'(1));
            if (q2.size() != 0) begin
                e = q2.pop_front();
                check("spawn2_slot", 32'(a), 32'(e.slot));
                check("spawn2_latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic pickup1(input bit tick_on_take);
        exp_t e;
        int   lat, s;
        bit   bad;
        bad   = 1'b0;
        take1 = 1'b1;
        tick1 = tick_on_take;
        @(negedge clk);
        take1 = 1'b0;
        tick1 = 1'b0;
        check("hide_t1", 32'(vis1), 32'(0));
        for (int k = 1; k <= RESP; k++) begin
            tick1 = 1'b1;
            @(negedge clk);
            tick1 = 1'b0;
            if (k < RESP && (vis1 !== exp_vis(k) || spn1 !== 1'b0)) bad = 1'b1;
        end
        check("hide_window", 32'(bad), 32'(0));
        check("pick_state", 32'(dut1.state), 32'(PICK));
        s = pick(m, cur1, 8, 4, lat);
        e = '{s, lat, cyc};
        q1.push_back(e);
        cur1 = s;
        for (int c = 0; c < 8 && q1.size() != 0; c++) @(negedge clk);
        check("spawn1_seen", 32'(q1.size()), 32'(0));
        @(negedge clk);
        check("spawn1_one_pulse", 32'(spn1), 32'(0));
        check("spawn1_stays_visible", 32'(vis1), 32'(1));
    endtask

    initial begin
        exp_t e;
        int   lat, s;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("lfsr_seed", 32'(dut1.u_lfsr.value), 32'(16'hACE1));
        check("rst_visible", 32'(vis1), 32'(1));
        check("rst_spawned", 32'(spn1), 32'(0));
        check("rst_slot", 32'(idx_of(p1.x, p1.y)), 32'(0));
        check("rst_state", 32'(dut1.state), 32'(SHOW));
        check("rst_visible2", 32'(vis2), 32'(1));

        pickup1(1'b0);
        pickup1(1'b1);
        pickup1(1'b0);

        // Restart mid-HIDE with a simultaneous pickup pulse
        take1 = 1'b1;
        @(negedge clk);
        take1 = 1'b0;
        repeat (30) begin
            tick1 = 1'b1;
            @(negedge clk);
            tick1 = 1'b0;
        end
        check("mid_hide_state", 32'(dut1.state), 32'(HIDE));
        reset1 = 1'b1;
        take1  = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        take1  = 1'b0;
        check("restart_visible", 32'(vis1), 32'(1));
        check("restart_slot", 32'(idx_of(p1.x, p1.y)), 32'(0));
        check("restart_state", 32'(dut1.state), 32'(SHOW));
        check("restart_spawned", 32'(spn1), 32'(0));
        @(negedge clk);
        check("restart_take_ignored", 32'(vis1), 32'(1));
        cur1 = 0;
        pickup1(1'b0);

        // Non-power-of-2 table, single try: fallback path is hit often
        for (int i = 0; i < 300; i++) begin
            take2 = 1'b1;
            @(negedge clk);
            take2 = 1'b0;
            tick2 = 1'b1;
            @(negedge clk);
            tick2 = 1'b0;
            s = pick(m, cur2, 5, 1, lat);
            e = '{s, lat, cyc};
            q2.push_back(e);
            cur2 = s;
            for (int c = 0; c < 4 && q2.size() != 0; c++) @(negedge clk);
            check("spawn2_seen", 32'(q2.size()), 32'(0));
        end
        check("slots2_all_used", 32'(used2), 32'(16'h001F));
        check("slots2_wrap_seen", 32'(wrap2), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
